hue_divider: RTL and testbench

- Fully pipelined unsigned fixed-point divider that replaces the vendor divider core behind the hue stage-0 divide.
- Responder side of the dividend/divisor stream interface: it accepts one unsigned operand pair per clock and returns floor(dividend*2^FRAC_W / divisor) with a divide-by-zero flag.
- Fixed latency, no backpressure, one result per clock.

---
 rtl/hue_pkg.sv | 22 ++
 rtl/hue_divider_if.sv | 35 +++
 rtl/hue_div_stage.sv | 44 ++++
 rtl/hue_divider.sv | 104 ++++++++++
 tb/tb_hue_divider.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hue_pkg.sv
// Shared constants and the pipeline stage record for the hue stage-0 divider.
package hue_pkg;

   localparam int unsigned HUE_DIVIDEND_W     = 8;
   localparam int unsigned HUE_DIVISOR_W      = 8;
   localparam int unsigned HUE_FRAC_W         = 6;
   localparam int unsigned HUE_DIV_OUT_W      = 16;
   localparam int unsigned HUE_NUM_W          = HUE_DIVIDEND_W + HUE_FRAC_W;
   localparam int unsigned HUE_REM_W          = HUE_DIVISOR_W + 1;
   localparam int unsigned HUE_DIVIDE_LATENCY = HUE_NUM_W + 2;

   // One in-flight division; numerator is the dividend pre-shifted by HUE_FRAC_W.
   typedef struct packed {
      logic                      valid;
      logic                      dbz;
      logic [HUE_NUM_W-1:0]      numerator;
      logic [HUE_DIVISOR_W-1:0]  divisor;
      logic [HUE_REM_W-1:0]      remainder;
      logic [HUE_NUM_W-1:0]      quotient;
   } hue_div_stage_t;

endpackage

// File: rtl/hue_divider_if.sv
// Operand/result stream bundle for hue_divider; o_dout_rem exists only with
// HUE_DIVIDER_REMAINDER_EN defined.
interface hue_divider_if;
   import hue_pkg::*;

   logic [HUE_DIVIDEND_W-1:0] i_dividend_data;
   logic                      i_dividend_valid;
   logic [HUE_DIVISOR_W-1:0]  i_divisor_data;
   logic                      i_divisor_valid;
   logic [HUE_DIV_OUT_W-1:0]  o_dout_data;
   logic                      o_dout_valid;
   logic                      o_dout_dbz;
`ifdef HUE_DIVIDER_REMAINDER_EN
   logic [HUE_DIVISOR_W-1:0]  o_dout_rem;

   modport master (
      output i_dividend_data, i_dividend_valid, i_divisor_data, i_divisor_valid,
      input  o_dout_data, o_dout_valid, o_dout_dbz, o_dout_rem
   );
   modport slave (
      input  i_dividend_data, i_dividend_valid, i_divisor_data, i_divisor_valid,
      output o_dout_data, o_dout_valid, o_dout_dbz, o_dout_rem
   );
`else
   modport master (
      output i_dividend_data, i_dividend_valid, i_divisor_data, i_divisor_valid,
      input  o_dout_data, o_dout_valid, o_dout_dbz
   );
   modport slave (
      input  i_dividend_data, i_dividend_valid, i_divisor_data, i_divisor_valid,
      output o_dout_data, o_dout_valid, o_dout_dbz
   );
`endif

endinterface

// File: rtl/hue_div_stage.sv
// One registered restoring-division step resolving quotient bit BIT.
module hue_div_stage
   import hue_pkg::*;
#(
   parameter int unsigned BIT = 0
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  hue_div_stage_t stage_i,
   output hue_div_stage_t stage_o
);

   localparam int unsigned TRIAL_W = HUE_REM_W + 1;

   hue_div_stage_t     stage_d;
   hue_div_stage_t     stage_q;
   logic [TRIAL_W-1:0] trial;
   logic [TRIAL_W-1:0] divisor_ext;

   // Shift in the next numerator bit, subtract when it fits, otherwise restore.
   always_comb begin
      stage_d     = stage_i;
      trial       = {stage_i.remainder, stage_i.numerator[BIT]};
      divisor_ext = TRIAL_W'(stage_i.divisor);
      if (trial >= divisor_ext) begin
         stage_d.remainder     = HUE_REM_W'(trial - divisor_ext);
         stage_d.quotient[BIT] = 1'b1;
      end else begin
         stage_d.remainder     = HUE_REM_W'(trial);
         stage_d.quotient[BIT] = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign stage_o = stage_q;

endmodule

// File: rtl/hue_divider.sv
// Fully pipelined unsigned divider: floor(dividend*2^FRAC_W / divisor), fixed latency.
// Optional HUE_DIVIDER_REMAINDER_EN adds the final partial remainder output.
module hue_divider
   import hue_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst,
   hue_divider_if.slave  dbus
);

   localparam int unsigned LAST = HUE_NUM_W - 1;

   hue_div_stage_t stage0_d;
   hue_div_stage_t stage0_q;
   hue_div_stage_t stage_in  [HUE_NUM_W];
   hue_div_stage_t stage_out [HUE_NUM_W];

   logic [HUE_DIV_OUT_W-1:0] dout_data_d, dout_data_q;
   logic                     dout_valid_d, dout_valid_q;
   logic                     dout_dbz_d, dout_dbz_q;

   // Input register: a pair is taken only when both operand valids are high.
   always_comb begin
      stage0_d           = '0;
      stage0_d.valid     = dbus.i_dividend_valid & dbus.i_divisor_valid;
      stage0_d.dbz       = (dbus.i_divisor_data == '0);
      stage0_d.numerator = {dbus.i_dividend_data, {HUE_FRAC_W{1'b0}}};
      stage0_d.divisor   = dbus.i_divisor_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stage0_q <= '0;
      end else begin
         stage0_q <= stage0_d;
      end
   end

   for (genvar g = 0; g < HUE_NUM_W; g++) begin : g_stage
      if (g == 0) begin : g_first
         assign stage_in[g] = stage0_q;
      end else begin : g_rest
         assign stage_in[g] = stage_out[g-1];
      end

      hue_div_stage #(
         .BIT (HUE_NUM_W - 1 - g)
      ) u_stage (
         .clk_i   (i_clk),
         .rst_i   (i_rst),
         .stage_i (stage_in[g]),
         .stage_o (stage_out[g])
      );
   end

   // Output register: data is zeroed for bubbles and divide-by-zero results.
   always_comb begin
      dout_valid_d = stage_out[LAST].valid;
      dout_dbz_d   = stage_out[LAST].valid & stage_out[LAST].dbz;
      dout_data_d  = '0;
      if (stage_out[LAST].valid && !stage_out[LAST].dbz) begin
         dout_data_d = HUE_DIV_OUT_W'(stage_out[LAST].quotient);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dout_data_q  <= '0;
         dout_valid_q <= 1'b0;
         dout_dbz_q   <= 1'b0;
      end else begin
         dout_data_q  <= dout_data_d;
         dout_valid_q <= dout_valid_d;
         dout_dbz_q   <= dout_dbz_d;
      end
   end

   assign dbus.o_dout_data  = dout_data_q;
   assign dbus.o_dout_valid = dout_valid_q;
   assign dbus.o_dout_dbz   = dout_dbz_q;

`ifdef HUE_DIVIDER_REMAINDER_EN
   logic [HUE_DIVISOR_W-1:0] dout_rem_d, dout_rem_q;

   // The remainder never reaches the divisor, so its top bit is always clear.
   always_comb begin
      dout_rem_d = '0;
      if (stage_out[LAST].valid && !stage_out[LAST].dbz) begin
         dout_rem_d = HUE_DIVISOR_W'(stage_out[LAST].remainder);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dout_rem_q <= '0;
      end else begin
         dout_rem_q <= dout_rem_d;
      end
   end

   assign dbus.o_dout_rem = dout_rem_q;
`endif

endmodule

// File: tb/tb_hue_divider.sv
// Self-checking bench for hue_divider: directed table, random streaming against
// an arithmetic model, handshake and mid-flight reset sequences.
module tb_hue_divider;
   import hue_pkg::*;

   localparam int unsigned LAT_EDGES = HUE_DIVIDE_LATENCY - 1;

   typedef struct {
      string       name;
      int unsigned a;
      int unsigned b;
      int unsigned q;
      int unsigned dbz;
      int unsigned rem;
   } vec_t;

   typedef struct {
      int unsigned a;
      int unsigned b;
      int unsigned due;
   } pend_t;

   logic        clk;
   logic        rst;
   int unsigned edge_cnt;
   int unsigned valid_seen;
   int          n_checks;
   int          n_fail;
   pend_t       sb_q[$];
   vec_t        vecs[8];

   hue_divider_if dif();

   hue_divider dut (
      .i_clk (clk),
      .i_rst (rst),
      .dbus  (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   function automatic int unsigned model_q(input int unsigned a, input int unsigned b);
      if (b == 0) return 0;
      return (a * 64) / b;
   endfunction

   function automatic int unsigned model_r(input int unsigned a, input int unsigned b);
      if (b == 0) return 0;
      return (a * 64) % b;
   endfunction

   function automatic vec_t mk(input string n, input int unsigned a, input int unsigned b,
                               input int unsigned q, input int unsigned d, input int unsigned r);
      vec_t v;
      v.name = n; v.a = a; v.b = b; v.q = q; v.dbz = d; v.rem = r;
      return v;
   endfunction

   // Record every accepted pair with the edge its result must appear on.
   always @(posedge clk) begin
      if (rst) begin
         sb_q.delete();
      end else if (dif.i_dividend_valid === 1'b1 && dif.i_divisor_valid === 1'b1) begin
         sb_q.push_back('{a: 32'(dif.i_dividend_data), b: 32'(dif.i_divisor_data),
                          due: edge_cnt + 1 + LAT_EDGES});
      end
      edge_cnt <= edge_cnt + 1;
   end

   // Output monitor: in-order scoreboard with exact latency.
   always @(negedge clk) begin
      pend_t e;
      if (dif.o_dout_valid === 1'b1) begin
         valid_seen++;
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got valid=1 at edge %0d required no result", edge_cnt);
         end else begin
            e = sb_q.pop_front();
            check("sb_latency", 32'(edge_cnt), 32'(e.due));
            check("sb_data", 32'(dif.o_dout_data), 32'(model_q(e.a, e.b)));
            check("sb_dbz", 32'(dif.o_dout_dbz), 32'(e.b == 0));
`ifdef HUE_DIVIDER_REMAINDER_EN
            check("sb_rem", 32'(dif.o_dout_rem), 32'(model_r(e.a, e.b)));
`endif
         end
      end else begin
         check("idle_valid", 32'(dif.o_dout_valid), 32'd0);
         check("idle_data", 32'(dif.o_dout_data), 32'd0);
         check("idle_dbz", 32'(dif.o_dout_dbz), 32'd0);
         if (sb_q.size() != 0 && sb_q[0].due <= edge_cnt) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_result: got valid=0 at edge %0d required result due %0d",
                     edge_cnt, sb_q[0].due);
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic drive_idle();
      dif.i_dividend_data  = '0;
      dif.i_dividend_valid = 1'b0;
      dif.i_divisor_data   = '0;
      dif.i_divisor_valid  = 1'b0;
   endtask

   // Issue one op (called at a negedge) and wait, bounded, for its result.
   task automatic run_single(input vec_t v);
      int  n;
      bit  got;
      dif.i_dividend_data  = 8'(v.a);
      dif.i_divisor_data   = 8'(v.b);
      dif.i_dividend_valid = 1'b1;
      dif.i_divisor_valid  = 1'b1;
      @(negedge clk);
      drive_idle();
      n   = 0;
      got = 1'b0;
      while (n < 40 && !got) begin
         @(negedge clk);
         n++;
         if (dif.o_dout_valid === 1'b1) got = 1'b1;
      end
      check({v.name, "_lat"}, 32'(n), 32'(LAT_EDGES));
      if (got) begin
         check({v.name, "_data"}, 32'(dif.o_dout_data), 32'(v.q));
         check({v.name, "_dbz"}, 32'(dif.o_dout_dbz), 32'(v.dbz));
`ifdef HUE_DIVIDER_REMAINDER_EN
         check({v.name, "_rem"}, 32'(dif.o_dout_rem), 32'(v.rem));
`endif
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int unsigned v0;
      int          acc;
      int          n;

      vecs[0] = mk("single",  200, 100, 16'h0080, 0, 0);
      vecs[1] = mk("max",     255,   1, 16'h3FC0, 0, 0);
      vecs[2] = mk("third",     1,   3, 16'h0015, 0, 1);
      vecs[3] = mk("zero_num",  0,   7, 16'h0000, 0, 0);
      vecs[4] = mk("near_one", 254, 255, 16'h003F, 0, 191);
      vecs[5] = mk("dbz",       7,   0, 16'h0000, 1, 0);
      vecs[6] = mk("after_dbz", 9,   3, 16'h00C0, 0, 0);
      vecs[7] = mk("seventh", 100,   7, 16'h0392, 0, 2);

      n_checks   = 0;
      n_fail     = 0;
      edge_cnt   = 0;
      valid_seen = 0;
      rst        = 1'b1;
      drive_idle();
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(dif.o_dout_valid), 32'd0);
      check("rst_data", 32'(dif.o_dout_data), 32'd0);
      check("rst_dbz", 32'(dif.o_dout_dbz), 32'd0);
`ifdef HUE_DIVIDER_REMAINDER_EN
      check("rst_rem", 32'(dif.o_dout_rem), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) run_single(vecs[i]);

      // Lone valids must never be accepted.
      v0 = valid_seen;
      dif.i_dividend_data  = 8'd50;
      dif.i_divisor_data   = 8'd5;
      dif.i_dividend_valid = 1'b1;
      repeat (5) @(negedge clk);
      dif.i_dividend_valid = 1'b0;
      dif.i_divisor_valid  = 1'b1;
      repeat (5) @(negedge clk);
      drive_idle();
      repeat (25) @(negedge clk);
      check("lone_valid", 32'(valid_seen - v0), 32'd0);

      // Random streaming with bubbles and occasional lone valids.
      acc = 0;
      while (acc < 300) begin
         dif.i_dividend_data = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) begin
            dif.i_divisor_data   = 8'($urandom_range(0, 255));
            dif.i_dividend_valid = 1'($urandom_range(0, 1));
            dif.i_divisor_valid  = 1'b0;
         end else begin
            dif.i_divisor_data   = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            dif.i_dividend_valid = 1'b1;
            dif.i_divisor_valid  = 1'b1;
            acc++;
         end
         @(negedge clk);
      end
      drive_idle();
      n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("stream_drain", 32'(sb_q.size()), 32'd0);
      check("stream_count", 32'(valid_seen - v0), 32'd300);

      // Reset with eight operations in flight.
      for (int i = 0; i < 8; i++) begin
         dif.i_dividend_data  = 8'(10 + i * 20);
         dif.i_divisor_data   = 8'd3;
         dif.i_dividend_valid = 1'b1;
         dif.i_divisor_valid  = 1'b1;
         @(negedge clk);
      end
      drive_idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      v0  = valid_seen;
      check("mid_rst_valid", 32'(dif.o_dout_valid), 32'd0);
      check("mid_rst_data", 32'(dif.o_dout_data), 32'd0);
      check("mid_rst_dbz", 32'(dif.o_dout_dbz), 32'd0);
      repeat (30) @(negedge clk);
      check("flushed", 32'(valid_seen - v0), 32'd0);
      run_single(mk("post_rst", 123, 45, 16'h00AE, 0, 42));

      n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("final_drain", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
